// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared constants for the microprogram sequencer
package cpu_ctrl_pkg;

    localparam int DEF_CAR_W = 8;
    localparam int DEF_OPC_W = 7;
    localparam logic [7:0] DEF_RESET_ADDR = 8'h00;

    localparam logic [2:0] MS_INC = 3'b000;
    localparam logic [2:0] MS_NA  = 3'b001;
    localparam logic [2:0] MS_C   = 3'b010;
    localparam logic [2:0] MS_V   = 3'b011;
    localparam logic [2:0] MS_Z   = 3'b100;
    localparam logic [2:0] MS_N   = 3'b101;
    localparam logic [2:0] MS_NZ  = 3'b110;
    localparam logic [2:0] MS_STK = 3'b111;

endpackage

// File: rtl/micro_stack.sv
// rtl/micro_stack.sv - small LIFO for microsubroutine return addresses (built only with MICRO_STACK_EN)
`ifdef MICRO_STACK_EN
module micro_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [CW-1:0] cnt;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign top_data = mem[AW'(cnt - CW'(1))];

    // Occupancy: a push onto a full stack is silently dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (push && !full) begin
            cnt <= cnt + CW'(1);
        end else if (pop && !empty) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Entry storage, written at the current fill level
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[AW'(cnt)] <= push_data;
        end
    end

endmodule
`endif

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - CAR/PC/IR sequencer; MICRO_STACK_EN enables ms=111 call/return
module micro_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int CAR_W = DEF_CAR_W,
    parameter int PC_W  = 16,
    parameter int IR_W  = 16,
    parameter int OPC_W = DEF_OPC_W,
    parameter logic [CAR_W-1:0] RESET_ADDR = CAR_W'(DEF_RESET_ADDR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic [CAR_W-1:0] na,
    input  logic [2:0]       ms,
    input  logic             mc,
    input  logic             il,
    input  logic             pi,
    input  logic             pl,
    input  logic [IR_W-1:0]  instr_in,
    input  logic [PC_W-1:0]  pc_load_val,
    input  logic             flag_c,
    input  logic             flag_v,
    input  logic             flag_z,
    input  logic             flag_n,
    output logic [CAR_W-1:0] car,
    output logic [PC_W-1:0]  pc,
    output logic [IR_W-1:0]  ir,
`ifdef MICRO_STACK_EN
    output logic             stack_err,
`endif
    output logic [OPC_W-1:0] opcode
);

    logic [CAR_W-1:0] car_inc;
    logic [CAR_W-1:0] map_addr;
    logic [CAR_W-1:0] tgt;
    logic             taken;
    logic [CAR_W-1:0] car_next;

    assign opcode  = ir[IR_W-1 -: OPC_W];
    assign car_inc = car + CAR_W'(1);
    assign tgt     = mc ? map_addr : na;

    // Opcode map address: a leading 1, then the opcode, zero-padded below
    always_comb begin
        map_addr                    = '0;
        map_addr[CAR_W-1]           = 1'b1;
        map_addr[CAR_W-2 -: OPC_W]  = opcode;
    end

    // Branch condition chosen by the mux select
    always_comb begin
        taken = 1'b0;
        case (ms)
            MS_NA:   taken = 1'b1;
            MS_C:    taken = flag_c;
            MS_V:    taken = flag_v;
            MS_Z:    taken = flag_z;
            MS_N:    taken = flag_n;
            MS_NZ:   taken = !flag_z;
            default: taken = 1'b0;
        endcase
    end

`ifdef MICRO_STACK_EN
    logic             stk_push;
    logic             stk_pop;
    logic [CAR_W-1:0] stk_top;
    logic             stk_full;
    logic             stk_empty;
    logic             is_stk;

    assign is_stk   = !hold && (ms == MS_STK);
    assign stk_push = is_stk && !mc;
    assign stk_pop  = is_stk && mc;

    micro_stack #(
        .W     (CAR_W),
        .DEPTH (4)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (car_inc),
        .top_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Next CAR including call (jump to na) and return (pop, or restart if empty)
    always_comb begin
        car_next = taken ? tgt : car_inc;
        if (ms == MS_STK) begin
            if (!mc) begin
                car_next = na;
            end else begin
                car_next = stk_empty ? RESET_ADDR : stk_top;
            end
        end
    end

    // Sticky error on call-while-full or return-while-empty
    always_ff @(posedge clk) begin
        if (rst) begin
            stack_err <= 1'b0;
        end else if ((stk_push && stk_full) || (stk_pop && stk_empty)) begin
            stack_err <= 1'b1;
        end
    end
`else
    // Next CAR; ms=111 falls back to plain increment
    always_comb begin
        car_next = taken ? tgt : car_inc;
    end
`endif

    // Control address register
    always_ff @(posedge clk) begin
        if (rst) begin
            car <= RESET_ADDR;
        end else if (!hold) begin
            car <= car_next;
        end
    end

    // Program counter: load beats increment
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else if (!hold) begin
            if (pl) begin
                pc <= pc_load_val;
            end else if (pi) begin
                pc <= pc + PC_W'(1);
            end
        end
    end

    // Instruction register, independent of the PC strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            ir <= '0;
        end else if (!hold && il) begin
            ir <= instr_in;
        end
    end

endmodule
